// File: rtl/adder48_seq.sv
// Purpose : time-multiplexed NSLICE*16-bit adder built around one adder16 carry-select slice.
// Latency : operands accepted on edge 0, slices on edges 1..NSLICE, result valid after edge NSLICE.
// Backpr. : single operation in flight; in_ready low in RUN/DONE, result held until out_ready.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (A, B, cin)
//   out_valid/out_ready  result handshake (S, cout[, ovf])
//   A, B [W:1]           operands, S [W:1] sum, cin carry into bit 1, cout carry out of bit W
// Optional: define ADDER48_SEQ_OVF_EN to add the registered signed-overflow output ovf.

// Purpose : 16-bit carry-select adder (8-bit ripple low half, duplicated upper half).
// Latency : purely combinational.
// Backpr. : none.
module adder16 (
  input  logic [16:1] a,
  input  logic [16:1] b,
  input  logic        cin,
  output logic [16:1] s,
  output logic        c16,
  output logic        sx
);
  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  always_comb begin
    lo  = {1'b0, a[8:1]} + {1'b0, b[8:1]} + {8'b0, cin};
    hi0 = {1'b0, a[16:9]} + {1'b0, b[16:9]};
    hi1 = {1'b0, a[16:9]} + {1'b0, b[16:9]} + 9'd1;
    // upper half picked by the low-half carry
    s[8:1] = lo[7:0];
    if (lo[8]) begin
      s[16:9] = hi1[7:0];
      c16     = hi1[8];
    end else begin
      s[16:9] = hi0[7:0];
      c16     = hi0[8];
    end
    sx = (a[16] == b[16]) && (s[16] != a[16]);
  end
endmodule

module adder48_seq #(
  parameter  int NSLICE = 3,
  localparam int W      = 16 * NSLICE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:1]   A,
  input  logic [W:1]   B,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:1]   S,
`ifdef ADDER48_SEQ_OVF_EN
  output logic         ovf,
`endif
  output logic         cout
);
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] k_q;
  logic          carry_q;
  logic [W:1]    a_q;
  logic [W:1]    b_q;
  logic [16:1]   a_sl;
  logic [16:1]   b_sl;
  logic [16:1]   sum16;
  logic          c16;
  logic          sx_unused;
  logic          last;

  assign last     = (k_q == CW'(NSLICE - 1));
  assign in_ready = (state_q == IDLE) && rst_n;

  // slice select from the captured operands
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (k_q == i[CW-1:0]) begin
        a_sl = a_q[16*i+1 +: 16];
        b_sl = b_q[16*i+1 +: 16];
      end
    end
  end

  // carry_q is loaded with cin at capture, so slice 0 sees cin
  adder16 u_add (
    .a   (a_sl),
    .b   (b_sl),
    .cin (carry_q),
    .s   (sum16),
    .c16 (c16),
    .sx  (sx_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      S         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef ADDER48_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= cin;
            k_q     <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (k_q == i[CW-1:0]) S[16*i+1 +: 16] <= sum16;
          end
          carry_q <= c16;
          if (last) begin
            cout      <= c16;
            out_valid <= 1'b1;
`ifdef ADDER48_SEQ_OVF_EN
            // sum16[16] is S[W] on the final slice
            ovf       <= (a_q[W] == b_q[W]) && (sum16[16] != a_q[W]);
`endif
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder48_seq.sv
module tb_adder48_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [48:1] A;
  logic [48:1] B;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [48:1] S;
  logic        cout;
`ifdef ADDER48_SEQ_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  adder48_seq #(.NSLICE(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
`ifdef ADDER48_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  typedef struct {
    logic [48:1] s;
    logic        c;
    logic        v;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   hold  = 1'b0;
  bit   bp_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on the full-width operands
  function automatic exp_t model(input logic [48:1] a, input logic [48:1] b, input logic c, input int acc);
    exp_t   e;
    logic [49:1] full;
    longint sa;
    longint sb;
    longint ssum;
    full = {1'b0, a} + {1'b0, b} + {48'b0, c};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ssum = sa + sb + longint'(c);
    e.s   = full[48:1];
    e.c   = full[49];
    e.v   = (ssum > 64'sh7FFF_FFFF_FFFF) || (ssum < -64'sh8000_0000_0000);
    e.acc = acc;
    return e;
  endfunction

  // monitor: owns out_ready, checks latency on the rising out_valid and data on handshake
  initial begin : monitor
    bit   prev_ov;
    exp_t e;
    prev_ov   = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = hold ? 1'b0 : (bp_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
        else               chk("latency", 64'(cyc - q[0].acc), 64'd3);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("sum", 64'(S), 64'(e.s));
        chk("cout", 64'(cout), 64'(e.c));
`ifdef ADDER48_SEQ_OVF_EN
        chk("ovf", 64'(ovf), 64'(e.v));
`endif
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_op(input logic [48:1] a, input logic [48:1] b, input logic c, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    cin = c;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) q.push_back(model(a, b, c, cyc));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin : stim
    logic [48:1] s0;
    logic        c0;
    logic [48:1] ra;
    logic [48:1] rb;
    logic [48:1] corner [4];
    int          n;
    corner[0] = '1;
    corner[1] = 48'h0;
    corner[2] = 48'h7FFF_FFFF_FFFF;
    corner[3] = 48'h8000_0000_0000;

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(S), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);

    // carry across slice boundary, full wrap
    do_op(48'h0000_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b1);
    drain();
    do_op(48'hFFFF_FFFF_FFFF, 48'h0, 1'b1, 1'b1);
    drain();

    // backpressure: result held for 5 cycles, new request ignored
    hold = 1'b1;
    do_op(48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 64'(out_valid), 64'd1);
    s0 = S;
    c0 = cout;
    chk("bp_sum", 64'(s0), 64'h2345_6789_ABCD);
    in_valid = 1'b1; A = 48'h5; B = 48'h6; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s_stable", 64'(S), 64'(s0));
      chk("bp_cout_stable", 64'(cout), 64'(c0));
      chk("bp_valid_stable", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    hold = 1'b0;
    drain();
    repeat (6) @(negedge clk);
    chk("bp_no_extra", 64'(out_valid), 64'd0);

    // reset during the second RUN cycle discards the operation
    do_op(48'hABCD_0000_1234, 48'h0000_FFFF_0001, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_quiet", 64'(out_valid), 64'd0);
    end
    do_op(48'd1, 48'd1, 1'b0, 1'b1);
    drain();

    // signed overflow
    do_op(48'h7FFF_FFFF_FFFF, 48'd1, 1'b0, 1'b1);
    drain();

    // randomized with random backpressure
    bp_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 48'({$urandom(), $urandom()});
      rb = 48'({$urandom(), $urandom()});
      if (i % 5 == 0) ra = corner[$urandom_range(0, 3)];
      if (i % 7 == 0) rb = corner[$urandom_range(0, 3)];
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();
    bp_mode = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder48_seq.md
Name: adder48_seq

Overview:
- Time-multiplexed 48-bit adder wrapped around one instance of the team's 16-bit carry-select adder (adder16).
- Registers one 48-bit operand pair, then feeds adder16 one 16-bit slice per cycle, LSB slice first.
- Carry is passed between slices through a register; the assembled sum is presented on a valid/ready output.
- Area-reduced alternative to the fully parallel adder48 for low-throughput datapaths.

Parameters:
- NSLICE, 3, number of 16-bit slices; datapath width W = 16*NSLICE (default 48).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair and cin valid.
- in_ready  output  1  block can accept an operand pair.
- A  input  [W:1]  operand A.
- B  input  [W:1]  operand B.
- cin  input  1  carry-in to bit 1.
- out_valid  output  1  S and cout valid.
- out_ready  input  1  consumer accepts the result.
- S  output  [W:1]  sum.
- cout  output  1  carry out of bit W.

Behaviour:
- Reset: synchronous, active-low. On any clk edge with rst_n=0:
  - state <= IDLE, slice counter <= 0, carry register <= 0.
  - S <= 0, cout <= 0, out_valid <= 0.
  - Operand registers are cleared to 0.
- in_ready is combinational: 1 exactly when state==IDLE and rst_n=1.
- State machine:
  - IDLE: on in_valid & in_ready, capture A, B, cin; counter <= 0; go to RUN.
  - RUN: each cycle, adder16 receives A[16k+16:16k+1], B[16k+16:16k+1] and the carry register (cin when k=0).
    - Store adder16 S into S[16k+16:16k+1].
    - Carry register <= c16.
    - If k == NSLICE-1: cout <= c16, out_valid <= 1, go to DONE. Otherwise k <= k+1.
  - DONE: hold S, cout and out_valid=1 until out_ready=1. On that edge out_valid <= 0 and go to IDLE.
- Latency: accept on edge 0; slices are computed on edges 1..NSLICE; out_valid is high after edge NSLICE (3 cycles for the default).
- Throughput: at most one operation per NSLICE+2 cycles. There is no overlap; in_ready stays low in RUN and DONE.
- out_ready asserted while out_valid=0 has no effect.
- in_valid while in_ready=0 is ignored; the upstream must hold its data.
- Slices already written are visible on S during RUN. They have no meaning until out_valid=1.
- Carry wrap-around: all-ones + 1 gives S=0 and cout=1. There is no saturation.
- The adder16 sx output is unused.
- Reset asserted during RUN or DONE:
  - The in-flight operation is discarded; no result is produced.
  - out_valid is low on the cycle after the reset edge.

Optional Feature:
- Macro ADDER48_SEQ_OVF_EN.
- When defined:
  - Extra output ovf, 1 bit, two's-complement signed overflow: A[W]==B[W] and S[W]!=A[W].
  - ovf is registered with cout on the final slice and held in DONE.
  - ovf resets to 0 and is valid only when out_valid=1.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> in_ready=1, out_valid=0, S=0, cout=0.
- Slice carry propagation: A=0x0000FFFFFFFF, B=0x000000000001, cin=0 -> S=0x000100000000, cout=0. out_valid rises exactly 3 cycles after the accepting edge.
- Full wrap: A=0xFFFFFFFFFFFF, B=0, cin=1 -> S=0x000000000000, cout=1. With ADDER48_SEQ_OVF_EN, ovf=0.
- Backpressure: result 0x123456789ABC+0x111111111111=0x23456789ABCD with out_ready=0 for 5 cycles -> S, cout and out_valid remain stable. in_ready=0 throughout, and a new in_valid in that window is not accepted.
- Reset mid-operation: rst_n=0 for 1 cycle during the second RUN cycle -> out_valid never rises for that operation, and in_ready=1 on the next cycle. A following add 1+1 returns S=2.
- Signed overflow (macro on): A=0x7FFFFFFFFFFF, B=1 -> S=0x800000000000, cout=0, ovf=1.
